// File: rtl/mpu_pkg.sv
// Shared definitions for region_mpu: FSM states, access types,
// register offsets in the config window and bit positions.
package mpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } acc_t;

  // Word offsets inside the 64-word config window
  localparam int         CFG_WORDS        = 64;
  localparam logic [5:0] OFF_CTRL         = 6'd0;
  localparam logic [5:0] OFF_FAULT_ADDR   = 6'd1;
  localparam logic [5:0] OFF_FAULT_PC     = 6'd2;
  localparam logic [5:0] OFF_FAULT_STATUS = 6'd3;
  // Region i occupies row (i + REGION_ROW0) of four words
  localparam int         REGION_ROW0      = 2;
  localparam logic [1:0] SUB_BASE         = 2'd0;
  localparam logic [1:0] SUB_LIMIT        = 2'd1;
  localparam logic [1:0] SUB_PERM         = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DEF  = 1;
  localparam int PERM_R    = 0;
  localparam int PERM_W    = 1;
  localparam int PERM_X    = 2;
  localparam int PERM_LOCK = 3;
  localparam int FS_VALID  = 0;
  localparam int FS_R      = 1;
  localparam int FS_W      = 2;
  localparam int FS_X      = 3;

  // Does a PERM nibble grant the given access type
  function automatic logic perm_allows(input logic [3:0] perm, input acc_t acc);
    case (acc)
      ACC_R:   return perm[PERM_R];
      ACC_W:   return perm[PERM_W];
      ACC_X:   return perm[PERM_X];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/region_mpu_match.sv
// One protection region: inclusive base/limit compare plus permission lookup.
module region_mpu_match
  import mpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 22
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] limit,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            perm,
  input  acc_t                  acc,
  output logic                  hit,
  output logic                  allow
);

  assign hit   = (addr >= base) && (addr <= limit);
  assign allow = perm_allows(perm, acc);

endmodule

// File: rtl/region_mpu.sv
// Multi-region memory protection unit between the picorv32 native memory
// interface and a single-port SRAM. Each request runs IDLE -> CHECK -> RESP.
// Handshake: cpu_valid is sampled only in IDLE; the request fields are latched
// there, and cpu_ready pulses for exactly one cycle in RESP, two cycles later.
// Optional macro MPU_LOCK_EN: PERM.LOCK freezes a region's BASE/LIMIT/PERM.
module region_mpu
  import mpu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 22,
  parameter int                    NUM_REGIONS = 4,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE    = ADDR_WIDTH'('h400)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  is_inst,
  input  logic [31:0]           pc_addr,
  output logic                  cpu_wait,
  output logic                  interrupt,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                  state, next_state;
  logic                    inst_q;
  logic [31:0]             pc_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wstrb_q;
  logic                    mem_rd_q, cfg_rd_q;

  logic [1:0]              ctrl;
  logic [ADDR_WIDTH-1:0]   fault_addr;
  logic [31:0]             fault_pc;
  logic [3:0]              fault_status;
  logic [ADDR_WIDTH-1:0]   base  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]   limit [NUM_REGIONS];
  logic [3:0]              perm  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]  locked;

  acc_t                    acc;
  logic [ADDR_WIDTH-1:0]   cfg_rel;
  logic                    in_cfg;
  logic [5:0]              cfg_off;
  logic [3:0]              cfg_row;
  logic [1:0]              cfg_sub;
  logic                    cfg_wr;
  logic [NUM_REGIONS-1:0]  hit, allow;
  logic                    any_hit, win_allow, mem_ok, deny;
  logic [DATA_WIDTH-1:0]   cfg_rdata;

  assign acc     = inst_q ? ACC_X : ((wstrb_q == 4'h0) ? ACC_R : ACC_W);
  assign cfg_rel = addr_q - CFG_BASE;
  assign in_cfg  = (addr_q >= CFG_BASE) && (cfg_rel < ADDR_WIDTH'(CFG_WORDS));
  assign cfg_off = cfg_rel[5:0];
  assign cfg_row = cfg_off[5:2];
  assign cfg_sub = cfg_off[1:0];
  // Only full-word, non-fetch accesses may modify config registers
  assign cfg_wr  = (state == ST_CHECK) && in_cfg && !inst_q && (wstrb_q == 4'hF);

  assign cpu_wait  = (state != ST_IDLE);
  assign interrupt = fault_status[FS_VALID];

  genvar g;
  for (g = 0; g < NUM_REGIONS; g++) begin : g_region
    region_mpu_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .base  (base[g]),
      .limit (limit[g]),
      .addr  (addr_q),
      .perm  (perm[g]),
      .acc   (acc),
      .hit   (hit[g]),
      .allow (allow[g])
    );
  end

`ifdef MPU_LOCK_EN
  // A set LOCK bit freezes that region's registers until reset
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) locked[i] = perm[i][PERM_LOCK];
  end
`else
  assign locked = '0;
`endif

  // Priority encoder: scan high to low so the lowest matching index wins
  always_comb begin
    any_hit   = 1'b0;
    win_allow = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit   = 1'b1;
        win_allow = allow[i];
      end
    end
  end

  // Memory access allowed; window accesses never reach memory, fetches there fault
  assign mem_ok = !in_cfg && (!ctrl[CTRL_EN] || (any_hit ? win_allow : ctrl[CTRL_DEF]));
  assign deny   = in_cfg ? inst_q : !mem_ok;

  // Config register read mux; unmapped offsets read as zero
  always_comb begin
    cfg_rdata = '0;
    case (cfg_off)
      OFF_CTRL:         cfg_rdata = DATA_WIDTH'(ctrl);
      OFF_FAULT_ADDR:   cfg_rdata = DATA_WIDTH'(fault_addr);
      OFF_FAULT_PC:     cfg_rdata = DATA_WIDTH'(fault_pc);
      OFF_FAULT_STATUS: cfg_rdata = DATA_WIDTH'(fault_status);
      default:          ;
    endcase
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_row == 4'(i + REGION_ROW0)) begin
        case (cfg_sub)
          SUB_BASE:  cfg_rdata = DATA_WIDTH'(base[i]);
          SUB_LIMIT: cfg_rdata = DATA_WIDTH'(limit[i]);
          SUB_PERM:  cfg_rdata = DATA_WIDTH'(perm[i]);
          default:   ;
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // FSM next state and interface outputs
  always_comb begin
    next_state = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_wen    = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: if (cpu_valid) next_state = ST_CHECK;
      ST_CHECK: begin
        next_state = ST_RESP;
        if (mem_ok) begin
          mem_addr = addr_q;
          if (acc == ACC_W) begin
            mem_wdata = wdata_q;
            mem_wen   = wstrb_q;
          end
        end
      end
      ST_RESP: begin
        next_state = ST_IDLE;
        cpu_ready  = 1'b1;
        if (mem_rd_q)      cpu_rdata = mem_rdata;
        else if (cfg_rd_q) cpu_rdata = cfg_rdata;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture the request when it is accepted in IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_q  <= 1'b0;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'h0;
    end else if (state == ST_IDLE && cpu_valid) begin
      inst_q  <= is_inst;
      pc_q    <= pc_addr;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
      wstrb_q <= cpu_wstrb;
    end
  end

  // Remember in CHECK where the RESP read data must come from
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rd_q <= 1'b0;
      cfg_rd_q <= 1'b0;
    end else if (state == ST_CHECK) begin
      mem_rd_q <= mem_ok && (acc != ACC_W);
      cfg_rd_q <= in_cfg && (acc == ACC_R);
    end
  end

  // Config registers and sticky first-fault capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl         <= 2'b00;
      fault_addr   <= '0;
      fault_pc     <= '0;
      fault_status <= 4'h0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base[i]  <= '0;
        limit[i] <= '0;
        perm[i]  <= 4'h0;
      end
    end else begin
      if (state == ST_CHECK && deny && !fault_status[FS_VALID]) begin
        fault_addr   <= addr_q;
        fault_pc     <= pc_q;
        fault_status <= {acc == ACC_X, acc == ACC_W, acc == ACC_R, 1'b1};
      end
      if (cfg_wr) begin
        case (cfg_off)
          OFF_CTRL:         ctrl <= wdata_q[1:0];
          OFF_FAULT_STATUS: if (wdata_q[FS_VALID]) fault_status <= 4'h0;
          default:          ;
        endcase
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (cfg_row == 4'(i + REGION_ROW0) && !locked[i]) begin
            case (cfg_sub)
              SUB_BASE:  base[i]  <= wdata_q[ADDR_WIDTH-1:0];
              SUB_LIMIT: limit[i] <= wdata_q[ADDR_WIDTH-1:0];
              SUB_PERM:  perm[i]  <= wdata_q[3:0];
              default:   ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_region_mpu.sv
// Testbench for region_mpu: directed scenarios followed by randomized
// accesses, all checked against a behavioural model of the MPU rules.
module tb_region_mpu;

  localparam int          DW  = 32;
  localparam int          AW  = 22;
  localparam int          NR  = 4;
  localparam logic [21:0] CFG = 22'h400;
`ifdef MPU_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          is_inst = 1'b0;
  logic [31:0]   pc_addr = '0;
  logic          cpu_wait, interrupt, cpu_ready;
  logic          cpu_valid = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [3:0]    cpu_wstrb = '0;
  logic [DW-1:0] cpu_rdata;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  region_mpu #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGIONS(NR), .CFG_BASE(CFG)
  ) dut (
    .clk(clk), .resetn(resetn), .is_inst(is_inst), .pc_addr(pc_addr),
    .cpu_wait(cpu_wait), .interrupt(interrupt), .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- SRAM environment (1K words, registered read) ----------------
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= sram[mem_addr[9:0]];
  end

  // ---------------- reference model state ----------------
  logic [1:0]  m_ctrl;
  logic [21:0] m_fa;
  logic [31:0] m_fpc;
  logic [3:0]  m_fs;
  logic [21:0] m_base  [NR];
  logic [21:0] m_limit [NR];
  logic [3:0]  m_perm  [NR];
  logic [31:0] m_mem   [0:1023];

  task automatic model_reset();
    m_ctrl = '0; m_fa = '0; m_fpc = '0; m_fs = '0;
    for (int i = 0; i < NR; i++) begin
      m_base[i] = '0; m_limit[i] = '0; m_perm[i] = '0;
    end
  endtask

  function automatic logic [31:0] m_reg_read(input int off);
    int i, k;
    if (off == 0) return 32'(m_ctrl);
    if (off == 1) return 32'(m_fa);
    if (off == 2) return m_fpc;
    if (off == 3) return 32'(m_fs);
    if (off >= 8 && off < 8 + 4 * NR) begin
      i = (off - 8) / 4;
      k = (off - 8) % 4;
      if (k == 0) return 32'(m_base[i]);
      if (k == 1) return 32'(m_limit[i]);
      if (k == 2) return 32'(m_perm[i]);
    end
    return 32'h0;
  endfunction

  task automatic m_reg_write(input int off, input logic [31:0] wd);
    int i, k;
    if (off == 0) m_ctrl = wd[1:0];
    if (off == 3 && wd[0]) m_fs = 4'h0;
    if (off >= 8 && off < 8 + 4 * NR) begin
      i = (off - 8) / 4;
      k = (off - 8) % 4;
      if (!(LOCK_EN && m_perm[i][3])) begin
        if (k == 0) m_base[i]  = wd[21:0];
        if (k == 1) m_limit[i] = wd[21:0];
        if (k == 2) m_perm[i]  = wd[3:0];
      end
    end
  endtask

  // Predict one transaction's outcome and update the model
  task automatic model_txn(input logic inst, input logic [31:0] pc, input logic [21:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           output logic [31:0] exp_rd, output int exp_wen);
    bit fault, allowed, found;
    int need;  // 0 read, 1 write, 2 execute
    exp_rd = 0; exp_wen = 0; fault = 0; found = 0; allowed = 0;
    need = inst ? 2 : ((ws == 0) ? 0 : 1);
    if (addr >= CFG && addr < CFG + 64) begin
      if (inst)          fault = 1;
      else if (ws == 0)  exp_rd = m_reg_read(int'(addr - CFG));
      else if (ws == 15) m_reg_write(int'(addr - CFG), wd);
    end else begin
      if (!m_ctrl[0]) allowed = 1;
      else begin
        for (int i = 0; i < NR; i++) begin
          if (!found && addr >= m_base[i] && addr <= m_limit[i]) begin
            found = 1;
            allowed = (need == 0) ? m_perm[i][0] : (need == 1) ? m_perm[i][1] : m_perm[i][2];
          end
        end
        if (!found) allowed = m_ctrl[1];
      end
      if (!allowed) fault = 1;
      else if (need == 1) begin
        exp_wen = 1;
        for (int b = 0; b < 4; b++) if (ws[b]) m_mem[addr[9:0]][8*b +: 8] = wd[8*b +: 8];
      end else exp_rd = m_mem[addr[9:0]];
    end
    if (fault && !m_fs[0]) begin
      m_fa  = addr;
      m_fpc = pc;
      m_fs  = {need == 2, need == 1, need == 0, 1'b1};
    end
  endtask

  // ---------------- comparison helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one transaction, starting and ending at a negedge ----------------
  task automatic dut_txn(input logic inst, input logic [31:0] pc, input logic [21:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] rd, output int lat, output int wen_cnt,
                         output logic wait_chk);
    is_inst = inst; pc_addr = pc; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = ws;
    cpu_valid = 1'b1;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    lat = 0; wen_cnt = 0; rd = '0; wait_chk = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) wait_chk = cpu_wait;
      if (mem_wen != 4'h0) wen_cnt++;
      if (cpu_ready) begin
        lat = c; rd = cpu_rdata;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic inst, input logic [31:0] pc,
                     input logic [21:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    logic [31:0] exp_rd;
    int lat, wen_cnt, exp_wen;
    logic wait_chk;
    dut_txn(inst, pc, addr, wd, ws, rd, lat, wen_cnt, wait_chk);
    model_txn(inst, pc, addr, wd, ws, exp_rd, exp_wen);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".latency"}, 32'(lat), 32'd2);
    check({tag, ".wen_pulses"}, 32'(wen_cnt), 32'(exp_wen));
    check({tag, ".wait"}, 32'(wait_chk), 32'd1);
    check({tag, ".irq"}, 32'(interrupt), 32'(m_fs[0]));
  endtask

  task automatic cfg_wr(input int off, input logic [31:0] wd);
    logic [31:0] rd;
    run("cfg_wr", 1'b0, 32'h0, CFG + 22'(off), wd, 4'hF, rd);
  endtask

  task automatic cfg_rd(input int off, output logic [31:0] rd);
    run("cfg_rd", 1'b0, 32'h0, CFG + 22'(off), 32'h0, 4'h0, rd);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] v;
    logic [21:0] a;
    logic [3:0]  ws;
    int          b, l;

    for (int i = 0; i < 1024; i++) begin
      sram[i]  = $urandom;
      m_mem[i] = sram[i];
    end
    sram[10'h080]  = 32'hDEADBEEF;
    m_mem[10'h080] = 32'hDEADBEEF;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst.interrupt", 32'(interrupt), 32'd0);
    check("rst.cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst.cpu_rdata", cpu_rdata, 32'd0);
    check("rst.mem_wen", 32'(mem_wen), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // MPU disabled: plain read passes through
    run("t1_read", 1'b0, 32'h0, 22'h080, 32'h0, 4'h0, rd);
    check("t1.rdata_literal", rd, 32'hDEADBEEF);
    check("t1.irq_literal", 32'(interrupt), 32'd0);

    // Region0 RWX, region1 no access, enabled with default allow
    cfg_wr(8, 32'h000); cfg_wr(9, 32'h0FF); cfg_wr(10, 32'h7);
    cfg_wr(12, 32'h100); cfg_wr(13, 32'h1FF); cfg_wr(14, 32'h0);
    cfg_wr(0, 32'h3);
    run("t2_store", 1'b0, 32'h40, 22'h150, 32'h12345678, 4'hF, rd);
    check("t2.irq_literal", 32'(interrupt), 32'd1);
    cfg_rd(1, rd); check("t2.fault_addr", rd, 32'h150);
    cfg_rd(2, rd); check("t2.fault_pc", rd, 32'h40);
    cfg_rd(3, rd); check("t2.fault_status", rd, 32'h5);

    // Second fault is dropped; clearing removes the interrupt
    run("t3_load", 1'b0, 32'h44, 22'h1A0, 32'h0, 4'h0, rd);
    check("t3.rdata_zero", rd, 32'h0);
    cfg_rd(1, rd); check("t3.fault_addr_sticky", rd, 32'h150);
    cfg_wr(3, 32'h1);
    check("t3.irq_cleared", 32'(interrupt), 32'd0);

    // Overlap: lower index (read-only) wins over RW region
    cfg_wr(9, 32'h1FF); cfg_wr(10, 32'h1); cfg_wr(14, 32'h3);
    run("t4_store", 1'b0, 32'h48, 22'h120, 32'hCAFE0001, 4'hF, rd);
    cfg_rd(3, rd); check("t4.fault_status", rd, 32'h5);
    cfg_rd(1, rd); check("t4.fault_addr", rd, 32'h120);
    cfg_wr(3, 32'h1);

    // Fetch from config window faults with X; partial config write ignored
    run("t5_fetch", 1'b1, 32'h1000, CFG, 32'h0, 4'h0, rd);
    cfg_rd(3, rd); check("t5.fault_status", rd, 32'h9);
    cfg_wr(3, 32'h1);
    run("t5_partial", 1'b0, 32'h0, CFG, 32'h0, 4'h3, rd);
    cfg_rd(0, rd); check("t5.ctrl_kept", rd, 32'h3);

    // LOCK behaviour (effective only when the lock feature is built in)
    cfg_wr(10, 32'hF);
    cfg_wr(8, 32'h300);
    cfg_rd(8, rd); check("t6.base0", rd, LOCK_EN ? 32'h0 : 32'h300);

    // Reset in the middle of an allowed store
    cfg_wr(0, 32'h0);
    is_inst = 1'b0; pc_addr = 32'h0; cpu_addr = 22'h050;
    cpu_wdata = 32'hA5A5A5A5; cpu_wstrb = 4'hF; cpu_valid = 1'b1;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    check("t7.wen_in_check", 32'(mem_wen), 32'hF);
    #1 resetn = 1'b0;
    #1;
    check("t7.mem_wen", 32'(mem_wen), 32'd0);
    check("t7.cpu_wait", 32'(cpu_wait), 32'd0);
    check("t7.cpu_ready", 32'(cpu_ready), 32'd0);
    check("t7.mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    check("t7.cpu_ready_held", 32'(cpu_ready), 32'd0);
    check("t7.sram_untouched", sram[10'h050], m_mem[10'h050]);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    cfg_rd(8, rd); check("t7.base0_cleared", rd, 32'h0);
    run("t7_read", 1'b0, 32'h0, 22'h050, 32'h0, 4'h0, rd);

    // Randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      if (t % 50 == 0) begin
        for (int i = 0; i < NR; i++) begin
          b = $urandom_range(0, 32'h3FF);
          l = b + $urandom_range(0, 32'h1FF) - 16;
          if (l > 32'h3FF) l = 32'h3FF;
          if (l < 0) l = 0;
          cfg_wr(8 + 4 * i, 32'(b));
          cfg_wr(9 + 4 * i, 32'(l));
          cfg_wr(10 + 4 * i, $urandom_range(0, 7));
        end
        cfg_wr(0, $urandom_range(0, 3));
      end
      case ($urandom_range(0, 9))
        0: begin
          a  = CFG + 22'($urandom_range(0, 63));
          ws = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
          run("rnd_cfg", 1'($urandom_range(0, 3) == 0), $urandom, a,
              $urandom_range(0, 32'h3FF), ws, rd);
        end
        1: cfg_wr(3, 32'h1);
        default: begin
          a  = 22'($urandom_range(0, 32'h3FF));
          ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          run("rnd_mem", 1'($urandom_range(0, 3) == 0), $urandom, a, $urandom, ws, rd);
        end
      endcase
    end

    // Read back the whole window
    for (int off = 0; off < 64; off++) begin
      cfg_rd(off, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
